// File: rtl/fetch_stream_buffer.sv
// Instruction-fetch front end: streams bus lines into a circular byte buffer and exposes a decode window.
// Optional MMIO fetch fault is compiled in when FETCH_MMIO_FAULT_EN is defined.

module fetch_stream_buffer #(
    parameter int          BUF_BYTES  = 128,
    parameter int          LINE_BYTES = 64,
    parameter int          BEAT_BYTES = 8,
    parameter int          WIN_BYTES  = 15,
    parameter logic [12:0] REQ_TAG    = 13'h100
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [63:0]                        entry,
    input  logic                               redirect,
    input  logic [63:0]                        redirect_addr,
    output logic                               req_cyc,
    input  logic                               req_ack,
    output logic [63:0]                        req_addr,
    output logic [12:0]                        req_tag,
    input  logic                               resp_cyc,
    input  logic [BEAT_BYTES*8-1:0]            resp_data,
    output logic                               resp_ack,
    output logic [WIN_BYTES*8-1:0]             win_bytes,
    output logic [63:0]                        win_addr,
    output logic [$clog2(WIN_BYTES+1)-1:0]     win_count,
    input  logic [$clog2(WIN_BYTES+1)-1:0]     consume,
    output logic                               fetch_fault
);

    localparam int AW     = $clog2(BUF_BYTES);
    localparam int PW     = AW + 1;
    localparam int CW     = $clog2(WIN_BYTES + 1);
    localparam int LW     = $clog2(LINE_BYTES);
    localparam int OW     = $clog2(BEAT_BYTES);
    localparam int WW     = $clog2(BEAT_BYTES + 1);
    localparam int NBEATS = LINE_BYTES / BEAT_BYTES;
    localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

`ifdef FETCH_MMIO_FAULT_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, ACTIVE, DRAIN, FAULT} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, WAIT, ACTIVE, DRAIN} state_t;
`endif

    logic [7:0]      mem [BUF_BYTES];
    state_t          state_reg;
    logic [PW-1:0]   fill_ptr_reg;
    logic [PW-1:0]   dec_ptr_reg;
    logic [63:0]     fetch_addr_reg;
    logic [63:0]     win_addr_reg;
    logic [LW-1:0]   skip_reg;
    logic [BCW-1:0]  beat_cnt_reg;
    logic            req_cyc_reg;
    logic [63:0]     req_addr_reg;

    logic [PW-1:0]   occupancy;
    logic            space_ok;
    logic [CW-1:0]   win_count_next;
    logic [CW-1:0]   cons_amt;
    logic [63:0]     line_addr;
    logic            beat_live;
    logic [BCW-1:0]  skip_beat;
    logic [WW-1:0]   skip_off;
    logic [WW-1:0]   wr_first;
    logic [WW-1:0]   wr_count;
    logic [BEAT_BYTES-1:0] wr_en;
    logic [AW-1:0]   wr_idx [BEAT_BYTES];

    assign occupancy      = fill_ptr_reg - dec_ptr_reg;
    assign space_ok       = occupancy <= PW'(BUF_BYTES - LINE_BYTES);
    assign win_count_next = (occupancy >= PW'(WIN_BYTES)) ? CW'(WIN_BYTES) : CW'(occupancy);
    assign cons_amt       = (consume > win_count_next) ? win_count_next : consume;
    assign line_addr      = fetch_addr_reg & ~64'(LINE_BYTES - 1);
    assign skip_beat      = BCW'(skip_reg >> OW);
    assign skip_off       = WW'(skip_reg & LW'(BEAT_BYTES - 1));
    assign beat_live      = resp_cyc && !redirect && !reset &&
                            (state_reg == WAIT || state_reg == ACTIVE);

    // Only the first line after a start address is trimmed; skip is zero afterwards.
    always_comb begin
        wr_first = '0;
        wr_count = '0;
        if (beat_live) begin
            if (beat_cnt_reg == skip_beat) begin
                wr_first = skip_off;
                wr_count = WW'(BEAT_BYTES) - skip_off;
            end else if (beat_cnt_reg > skip_beat) begin
                wr_count = WW'(BEAT_BYTES);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BEAT_BYTES; gi++) begin : g_wr
            assign wr_en[gi]  = (wr_count != '0) && (WW'(gi) >= wr_first);
            assign wr_idx[gi] = fill_ptr_reg[AW-1:0] + AW'(gi) - AW'(wr_first);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int j = 0; j < BEAT_BYTES; j++) begin
            if (wr_en[j]) begin
                mem[wr_idx[j]] <= resp_data[j*8 +: 8];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIN_BYTES; gi++) begin : g_win
            logic [AW-1:0] rd_idx;
            assign rd_idx = dec_ptr_reg[AW-1:0] + AW'(gi);
            assign win_bytes[gi*8 +: 8] = (CW'(gi) < win_count_next) ? mem[rd_idx] : 8'h00;
        end
    endgenerate

`ifdef FETCH_MMIO_FAULT_EN
    logic fetch_fault_reg;
    logic mmio_line;
    assign mmio_line   = (line_addr > 64'h000A_0000) && (line_addr < 64'h0010_0000);
    assign fetch_fault = fetch_fault_reg;
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            fill_ptr_reg   <= '0;
            dec_ptr_reg    <= '0;
            fetch_addr_reg <= entry;
            win_addr_reg   <= entry;
            skip_reg       <= entry[LW-1:0];
            beat_cnt_reg   <= '0;
            req_cyc_reg    <= 1'b0;
            req_addr_reg   <= '0;
`ifdef FETCH_MMIO_FAULT_EN
            fetch_fault_reg <= 1'b0;
`endif
        end else begin
            fill_ptr_reg <= fill_ptr_reg + PW'(wr_count);
            dec_ptr_reg  <= dec_ptr_reg + PW'(cons_amt);
            win_addr_reg <= win_addr_reg + 64'(cons_amt);
            case (state_reg)
                IDLE: begin
                    if (space_ok) begin
`ifdef FETCH_MMIO_FAULT_EN
                        if (mmio_line) begin
                            state_reg       <= FAULT;
                            fetch_fault_reg <= 1'b1;
                        end else
`endif
                        begin
                            state_reg    <= REQ;
                            req_cyc_reg  <= 1'b1;
                            req_addr_reg <= line_addr;
                        end
                    end
                end
                REQ: begin
                    if (req_ack) begin
                        req_cyc_reg <= 1'b0;
                        state_reg   <= WAIT;
                    end
                end
                WAIT, ACTIVE: begin
                    if (resp_cyc) begin
                        if (beat_cnt_reg == LAST_BEAT) begin
                            beat_cnt_reg   <= '0;
                            fetch_addr_reg <= fetch_addr_reg + 64'(LINE_BYTES);
                            skip_reg       <= '0;
                            state_reg      <= IDLE;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                            state_reg    <= ACTIVE;
                        end
                    end
                end
                DRAIN: begin
                    // A request caught by redirect before acceptance is still owed to the bus.
                    if (req_cyc_reg) begin
                        if (req_ack) begin
                            req_cyc_reg <= 1'b0;
                        end
                    end else if (resp_cyc) begin
                        if (beat_cnt_reg == LAST_BEAT) begin
                            beat_cnt_reg <= '0;
                            state_reg    <= IDLE;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (redirect) begin
                fill_ptr_reg   <= '0;
                dec_ptr_reg    <= '0;
                win_addr_reg   <= redirect_addr;
                fetch_addr_reg <= redirect_addr;
                skip_reg       <= redirect_addr[LW-1:0];
`ifdef FETCH_MMIO_FAULT_EN
                fetch_fault_reg <= 1'b0;
`endif
                case (state_reg)
                    REQ:   state_reg <= DRAIN;
                    WAIT, ACTIVE: begin
                        if (!(resp_cyc && beat_cnt_reg == LAST_BEAT)) begin
                            state_reg <= DRAIN;
                        end
                    end
                    DRAIN: ;
                    default: begin
                        state_reg   <= IDLE;
                        req_cyc_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign req_cyc   = req_cyc_reg;
    assign req_addr  = req_addr_reg;
    assign req_tag   = REQ_TAG;
    assign resp_ack  = resp_cyc;
    assign win_addr  = win_addr_reg;
    assign win_count = win_count_next;

endmodule
